// File: rtl/utf8_byte_encoder_if.sv
// Handshake bundle between the code-point FIFO, the UTF-8 encoder and its byte sink.
// The slave modport is the encoder's view; the master modport is the surrounding system's view.
interface utf8_byte_encoder_if #(
   parameter int DATA_WIDTH = 21
) ();
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_data_available;
   logic                  receiver_ready;
   logic [7:0]            byte_out;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  busy;

   modport slave (
      input  in_data,
      input  in_data_available,
      output receiver_ready,
      output byte_out,
      output byte_valid,
      input  byte_ready,
      output busy
   );

   modport master (
      output in_data,
      output in_data_available,
      input  receiver_ready,
      input  byte_out,
      input  byte_valid,
      output byte_ready,
      input  busy
   );
endinterface

// File: rtl/utf8_byte_encoder.sv
// Pulls one code point at a time from the FIFO and streams its 1-4 UTF-8 bytes
// on a valid/ready byte port; surrogates and out-of-range values become REPLACEMENT.
module utf8_byte_encoder #(
   parameter int          DATA_WIDTH  = 21,
   parameter logic [20:0] REPLACEMENT = 21'h00FFFD
) (
   input  logic               clk,
   input  logic               reset,
   utf8_byte_encoder_if.slave bus
);

   typedef enum logic {IDLE, EMIT} state_t;

   typedef struct packed {
      logic [1:0] last;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
   } enc_t;

   function automatic enc_t encode(input logic [20:0] cp_in);
      enc_t       e;
      logic [20:0] cp;
      logic       illegal;
      illegal = ((cp_in >= 21'h00D800) && (cp_in <= 21'h00DFFF)) || (cp_in > 21'h10FFFF);
      cp      = illegal ? REPLACEMENT : cp_in;
      e       = '0;
      if (cp < 21'h000080) begin
         e.last = 2'd0;
         e.b0   = {1'b0, cp[6:0]};
      end else if (cp < 21'h000800) begin
         e.last = 2'd1;
         e.b0   = {3'b110, cp[10:6]};
         e.b1   = {2'b10, cp[5:0]};
      end else if (cp < 21'h010000) begin
         e.last = 2'd2;
         e.b0   = {4'b1110, cp[15:12]};
         e.b1   = {2'b10, cp[11:6]};
         e.b2   = {2'b10, cp[5:0]};
      end else begin
         e.last = 2'd3;
         e.b0   = {5'b11110, cp[20:18]};
         e.b1   = {2'b10, cp[17:12]};
         e.b2   = {2'b10, cp[11:6]};
         e.b3   = {2'b10, cp[5:0]};
      end
      return e;
   endfunction

   state_t     state, state_next;
   logic [1:0] idx, idx_next;
   logic [1:0] last_idx, last_next;
   logic [7:0] byte_q, byte_next;
   logic       valid_q, valid_next;
   logic       load;
   logic [7:0] byte_reg [4];
   enc_t       enc;

   assign enc = encode(bus.in_data[20:0]);

   always_comb begin
      state_next = state;
      idx_next   = idx;
      last_next  = last_idx;
      byte_next  = byte_q;
      valid_next = valid_q;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_data_available) begin
               load       = 1'b1;
               last_next  = enc.last;
               idx_next   = 2'd0;
               byte_next  = enc.b0;
               valid_next = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            // Hold everything while the sink stalls; only a transfer advances the index.
            if (valid_q && bus.byte_ready) begin
               if (idx == last_idx) begin
                  valid_next = 1'b0;
                  state_next = IDLE;
               end else begin
                  idx_next  = idx + 2'd1;
                  byte_next = byte_reg[idx + 2'd1];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         idx      <= 2'd0;
         last_idx <= 2'd0;
         byte_q   <= 8'h00;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_next;
         idx      <= idx_next;
         last_idx <= last_next;
         byte_q   <= byte_next;
         valid_q  <= valid_next;
      end
   end

   // Byte buffer is pure data: no reset, written only when a code point is latched.
   always_ff @(posedge clk) begin
      if (load) begin
         byte_reg[0] <= enc.b0;
         byte_reg[1] <= enc.b1;
         byte_reg[2] <= enc.b2;
         byte_reg[3] <= enc.b3;
      end
   end

   assign bus.receiver_ready = (state == IDLE);
   assign bus.busy           = (state == EMIT);
   assign bus.byte_out       = byte_q;
   assign bus.byte_valid     = valid_q;

endmodule

// File: tb/tb_utf8_byte_encoder.sv
// Directed bench for utf8_byte_encoder: latency, encodings, stalls, illegal input,
// back-to-back traffic with a random sink, and asynchronous reset mid-emission.
module tb_utf8_byte_encoder;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   utf8_byte_encoder_if #(.DATA_WIDTH(21)) bus ();

   utf8_byte_encoder #(
      .DATA_WIDTH (21),
      .REPLACEMENT(21'h00FFFD)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Code point, expected bytes (byte 0 in bits 31:24), expected byte count.
   logic [20:0] bnd_cp  [11] = '{21'h00D800, 21'h00DFFF, 21'h110000, 21'h1FFFFF, 21'h00007F,
                                 21'h000080, 21'h0007FF, 21'h000800, 21'h00FFFF, 21'h010000,
                                 21'h10FFFF};
   logic [31:0] bnd_exp [11] = '{32'hEFBFBD00, 32'hEFBFBD00, 32'hEFBFBD00, 32'hEFBFBD00,
                                 32'h7F000000, 32'hC2800000, 32'hDFBF0000, 32'hE0A08000,
                                 32'hEFBFBF00, 32'hF0908080, 32'hF48FBFBF};
   int          bnd_n   [11] = '{3, 3, 3, 3, 1, 2, 2, 3, 3, 4, 4};

   logic [20:0] mix_cp  [8]  = '{21'h000041, 21'h0000E9, 21'h0020AC, 21'h01F600, 21'h00D800,
                                 21'h0007FF, 21'h10FFFF, 21'h000800};
   logic [31:0] mix_exp [8]  = '{32'h41000000, 32'hC3A90000, 32'hE282AC00, 32'hF09F9880,
                                 32'hEFBFBD00, 32'hDFBF0000, 32'hF48FBFBF, 32'hE0A08000};
   int          mix_n   [8]  = '{1, 2, 3, 4, 3, 2, 4, 3};

   task automatic push(input logic [20:0] cp);
      int waited = 0;
      @(negedge clk);
      while (!bus.receiver_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.receiver_ready) begin
         total++; bad++;
         $display("FAIL push_wait cp=%h receiver_ready=%b required 1", cp, bus.receiver_ready);
      end
      bus.in_data           = cp;
      bus.in_data_available = 1'b1;
      @(negedge clk);
      bus.in_data_available = 1'b0;
   endtask

   task automatic drain(input bit rnd, output logic [7:0] got [0:7], output int cnt);
      cnt = 0;
      for (int i = 0; i < 8; i++) got[i] = 8'h00;
      for (int c = 0; c < 60; c++) begin
         bit r;
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.byte_ready = r;
         if (!bus.byte_valid) break;
         if (r) begin
            if (cnt < 8) got[cnt] = bus.byte_out;
            cnt++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      bus.in_data           = '0;
      bus.in_data_available = 1'b0;
      bus.byte_ready        = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus.receiver_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.receiver_ready); end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.byte_valid); end
      total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", bus.byte_out); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_single;
      bus.byte_ready = 1'b1;
      push(21'h000041);
      total++; if (bus.byte_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.byte_valid); end
      total++; if (bus.byte_out !== 8'h41) begin bad++; $display("FAIL single_byte got=%h want=41", bus.byte_out); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus.busy); end
      total++; if (bus.receiver_ready !== 1'b0) begin bad++; $display("FAIL single_rr_emit got=%b want=0", bus.receiver_ready); end
      @(negedge clk);
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL single_valid_end got=%b want=0", bus.byte_valid); end
      total++; if (bus.receiver_ready !== 1'b1) begin bad++; $display("FAIL single_rr_end got=%b want=1", bus.receiver_ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", bus.busy); end
   endtask

   task automatic test_multi_byte;
      logic [7:0] got [0:7];
      int cnt;
      push(21'h0000E9);
      drain(1'b0, got, cnt);
      total++; if (cnt !== 2) begin bad++; $display("FAIL e9_count got=%0d want=2", cnt); end
      total++; if ({got[0], got[1]} !== 16'hC3A9) begin bad++; $display("FAIL e9_bytes got=%h%h want=C3A9", got[0], got[1]); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL e9_busy got=%b want=0", bus.busy); end
      push(21'h0020AC);
      drain(1'b0, got, cnt);
      total++; if (cnt !== 3) begin bad++; $display("FAIL euro_count got=%0d want=3", cnt); end
      total++; if ({got[0], got[1], got[2]} !== 24'hE282AC) begin bad++; $display("FAIL euro_bytes got=%h%h%h want=E282AC", got[0], got[1], got[2]); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL euro_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_ready_toggle;
      bit         pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp [4] = '{8'hF0, 8'h9F, 8'h98, 8'h80};
      int k = 0;
      bus.byte_ready = 1'b0;
      push(21'h01F600);
      for (int c = 0; c < 7; c++) begin
         bus.byte_ready = pat[c];
         total++;
         if (bus.byte_valid !== 1'b1 || bus.byte_out !== exp[k]) begin
            bad++;
            $display("FAIL toggle_c%0d got valid=%b byte=%h want valid=1 byte=%h", c, bus.byte_valid, bus.byte_out, exp[k]);
         end
         if (pat[c]) k++;
         @(negedge clk);
      end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL toggle_end_valid got=%b want=0", bus.byte_valid); end
   endtask

   task automatic test_boundaries;
      logic [7:0] got [0:7];
      int cnt;
      for (int t = 0; t < 11; t++) begin
         logic [31:0] e;
         e = bnd_exp[t];
         push(bnd_cp[t]);
         drain(1'b0, got, cnt);
         total++; if (cnt !== bnd_n[t]) begin bad++; $display("FAIL bnd_count cp=%h got=%0d want=%0d", bnd_cp[t], cnt, bnd_n[t]); end
         for (int i = 0; i < bnd_n[t]; i++) begin
            total++;
            if (got[i] !== e[31-8*i -: 8]) begin
               bad++;
               $display("FAIL bnd_byte cp=%h idx=%0d got=%h want=%h", bnd_cp[t], i, got[i], e[31-8*i -: 8]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_q [$];
      logic [7:0] got_q [$];
      for (int t = 0; t < 8; t++) begin
         logic [31:0] e;
         e = mix_exp[t];
         for (int i = 0; i < mix_n[t]; i++) exp_q.push_back(e[31-8*i -: 8]);
      end
      fork
         begin
            for (int t = 0; t < 8; t++) push(mix_cp[t]);
         end
         begin
            for (int c = 0; c < 2000 && got_q.size() < exp_q.size(); c++) begin
               bit r;
               @(negedge clk);
               r = 1'($urandom_range(0, 1));
               bus.byte_ready = r;
               if (bus.byte_valid && r) got_q.push_back(bus.byte_out);
            end
         end
      join
      repeat (3) @(negedge clk);
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte idx=%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra_valid got=%b want=0", bus.byte_valid); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] got [0:7];
      int cnt;
      bus.byte_ready = 1'b1;
      push(21'h0020AC);
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.byte_out !== 8'hAC) begin bad++; $display("FAIL mid_pre_byte got=%h want=AC", bus.byte_out); end
      bus.byte_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", bus.byte_valid); end
      total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL mid_byte got=%h want=00", bus.byte_out); end
      total++; if (bus.receiver_ready !== 1'b1) begin bad++; $display("FAIL mid_rr got=%b want=1", bus.receiver_ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
      @(negedge clk);
      reset = 1'b1;
      bus.byte_ready = 1'b1;
      push(21'h000041);
      drain(1'b0, got, cnt);
      total++; if (cnt !== 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", cnt); end
      total++; if (got[0] !== 8'h41) begin bad++; $display("FAIL mid_after_byte got=%h want=41", got[0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_byte();
      test_ready_toggle();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
